// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack core: command codes, error codes and FSM states.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_MUL   = 3'd4,
    OP_DUP   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_FULL  = 2'd1,
    ERR_UNDER = 2'd2,
    ERR_OVF   = 2'd3
  } err_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/rpn_mul_seq.sv
// Shift-add unsigned multiplier. The first partial product is taken on the start edge,
// so done_o is high in the cycle before the WIDTH-th edge after start.
module rpn_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNTW-1:0]    cnt_q;
  logic               done_q;

  // One multiplier bit per cycle; cnt_q holds the iterations still outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNTW{1'b0}};
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= b_i[0] ? {{WIDTH{1'b0}}, a_i} : {(2*WIDTH){1'b0}};
        mcand_q  <= {{(WIDTH-1){1'b0}}, a_i, 1'b0};
        mplier_q <= {1'b0, b_i[WIDTH-1:1]};
        cnt_q    <= CNTW'(WIDTH - 1);
      end else if (cnt_q != {CNTW{1'b0}}) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/rpn_stack_core.sv
// RPN evaluation core: register-array operand stack, single-cycle stack/add/sub ops
// and a multi-cycle multiply handed to rpn_mul_seq.
module rpn_stack_core
  import rpn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   stk_q [DEPTH];
  logic [CW-1:0]      count_q;
  state_e             state_q;
  err_e               err_q;
  logic               done_q;

  op_e                op_s;
  logic [AW-1:0]      top_idx_s, nxt_idx_s, push_idx_s;
  logic [WIDTH-1:0]   top_s, nxt_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic               mul_start_s, mul_done_s;
  logic [2*WIDTH-1:0] prod_s;

  assign op_s       = op_e'(op);
  assign top_idx_s  = AW'(count_q - CW'(1));
  assign nxt_idx_s  = AW'(count_q - CW'(2));
  assign push_idx_s = AW'(count_q);
  assign top_s      = (count_q >= CW'(1)) ? stk_q[top_idx_s] : {WIDTH{1'b0}};
  assign nxt_s      = (count_q >= CW'(2)) ? stk_q[nxt_idx_s] : {WIDTH{1'b0}};

  // Bit WIDTH of the sum is the carry, of the difference the borrow (top > next).
  assign sum_s  = {1'b0, nxt_s} + {1'b0, top_s};
  assign diff_s = {1'b0, nxt_s} - {1'b0, top_s};

  assign mul_start_s = (state_q == ST_IDLE) && op_valid && (op_s == OP_MUL) && (count_q >= CW'(2));

  rpn_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .start_i (mul_start_s),
    .a_i     (nxt_s),
    .b_i     (top_s),
    .done_o  (mul_done_s),
    .prod_o  (prod_s)
  );

  // Command FSM: stack, count, error and done pulse all update here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= {CW{1'b0}};
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            done_q <= 1'b1;
            case (op_s)
              OP_PUSH: begin
                if (count_q == CW'(DEPTH)) begin
                  err_q <= ERR_FULL;
                end else begin
                  stk_q[push_idx_s] <= data_in;
                  count_q <= count_q + CW'(1);
                  err_q   <= ERR_NONE;
                end
              end
              OP_POP: begin
                if (count_q == CW'(0)) begin
                  err_q <= ERR_UNDER;
                end else begin
                  stk_q[top_idx_s] <= {WIDTH{1'b0}};
                  count_q <= count_q - CW'(1);
                  err_q   <= ERR_NONE;
                end
              end
              OP_ADD, OP_SUB: begin
                if (count_q < CW'(2)) begin
                  err_q <= ERR_UNDER;
                end else begin
                  stk_q[nxt_idx_s] <= (op_s == OP_ADD) ? sum_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                  stk_q[top_idx_s] <= {WIDTH{1'b0}};
                  count_q <= count_q - CW'(1);
                  err_q   <= ((op_s == OP_ADD) ? sum_s[WIDTH] : diff_s[WIDTH]) ? ERR_OVF : ERR_NONE;
                end
              end
              OP_MUL: begin
                if (count_q < CW'(2)) begin
                  err_q <= ERR_UNDER;
                end else begin
                  done_q  <= 1'b0;
                  state_q <= ST_MUL;
                end
              end
              OP_DUP: begin
                if (count_q == CW'(0)) begin
                  err_q <= ERR_UNDER;
                end else if (count_q == CW'(DEPTH)) begin
                  err_q <= ERR_FULL;
                end else begin
                  stk_q[push_idx_s] <= top_s;
                  count_q <= count_q + CW'(1);
                  err_q   <= ERR_NONE;
                end
              end
              OP_SWAP: begin
                if (count_q < CW'(2)) begin
                  err_q <= ERR_UNDER;
                end else begin
                  stk_q[top_idx_s] <= nxt_s;
                  stk_q[nxt_idx_s] <= top_s;
                  err_q <= ERR_NONE;
                end
              end
              OP_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) stk_q[i] <= {WIDTH{1'b0}};
                count_q <= {CW{1'b0}};
                err_q   <= ERR_NONE;
              end
              default: err_q <= err_q;
            endcase
          end
        end
        ST_MUL: begin
          // Operands were latched by the multiplier, so the stack is still intact here.
          if (mul_done_s) begin
            stk_q[nxt_idx_s] <= prod_s[WIDTH-1:0];
            stk_q[top_idx_s] <= {WIDTH{1'b0}};
            count_q <= count_q - CW'(1);
            err_q   <= (|prod_s[2*WIDTH-1:WIDTH]) ? ERR_OVF : ERR_NONE;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign top   = top_s;
  assign next  = nxt_s;
  assign count = count_q;
  assign busy  = (state_q == ST_MUL);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Directed bench for rpn_stack_core (WIDTH=8, DEPTH=4) with a stack-model scoreboard.
module tb_rpn_stack_core;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [2:0] op;
  logic [7:0] data_in;
  logic [7:0] top_s, next_s;
  logic [2:0] count_s;
  logic       busy_s, done_s;
  logic [1:0] err_s;

  rpn_stack_core #(.WIDTH(8), .DEPTH(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .data_in  (data_in),
    .top      (top_s),
    .next     (next_s),
    .count    (count_s),
    .busy     (busy_s),
    .done     (done_s),
    .err      (err_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] nxt;
    logic [2:0] cnt;
    logic [1:0] err;
  } exp_t;

  exp_t       exp_q[$];
  int         m_stk[$];
  logic [1:0] m_err;
  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_done = 0;
  int         bc;

  // Counts done pulses as seen on each rising edge.
  always @(posedge clk) if (done_s === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_cmd(input op_e o, input logic [7:0] d);
    int n, a, b, r, t;
    exp_t e;
    n = m_stk.size();
    case (o)
      OP_PUSH: if (n == 4) m_err = 2'd1; else begin m_stk.push_back(int'(d)); m_err = 2'd0; end
      OP_POP:  if (n < 1) m_err = 2'd2; else begin void'(m_stk.pop_back()); m_err = 2'd0; end
      OP_ADD, OP_SUB, OP_MUL: begin
        if (n < 2) m_err = 2'd2;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          r = (o == OP_ADD) ? a + b : (o == OP_SUB) ? a - b : a * b;
          m_err = (r < 0 || r > 255) ? 2'd3 : 2'd0;
          m_stk.push_back(r & 255);
        end
      end
      OP_DUP: begin
        if (n < 1) m_err = 2'd2;
        else if (n == 4) m_err = 2'd1;
        else begin m_stk.push_back(m_stk[n-1]); m_err = 2'd0; end
      end
      OP_SWAP: begin
        if (n < 2) m_err = 2'd2;
        else begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; m_err = 2'd0; end
      end
      default: begin m_stk.delete(); m_err = 2'd0; end
    endcase
    n = m_stk.size();
    e.top = (n > 0) ? 8'(m_stk[n-1]) : 8'h00;
    e.nxt = (n > 1) ? 8'(m_stk[n-2]) : 8'h00;
    e.cnt = 3'(n);
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input op_e o, input logic [7:0] d);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    data_in  = d;
    model_cmd(o, d);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int busy_cycles);
    int budget;
    exp_t e;
    budget = 40;
    busy_cycles = 0;
    while (done_s !== 1'b1 && budget > 0) begin
      if (busy_s === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      budget--;
    end
    check({tag, "_done"}, 32'(done_s), 32'd1);
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    if (done_s === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_top"},   32'(top_s),   32'(e.top));
      check({tag, "_next"},  32'(next_s),  32'(e.nxt));
      check({tag, "_count"}, 32'(count_s), 32'(e.cnt));
      check({tag, "_err"},   32'(err_s),   32'(e.err));
    end
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done_s), 32'd0);
  endtask

  task automatic do_cmd(input op_e o, input logic [7:0] d, input string tag, input int exp_busy);
    int busy_cycles;
    issue(o, d);
    wait_done(tag, busy_cycles);
    if (exp_busy >= 0) check({tag, "_busycyc"}, 32'(busy_cycles), 32'(exp_busy));
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; data_in = 8'h00;
    m_err = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_top", 32'(top_s), 32'd0);
    check("rst_next", 32'(next_s), 32'd0);
    check("rst_count", 32'(count_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_err", 32'(err_s), 32'd0);
    n_done = 0;

    do_cmd(OP_PUSH, 8'h2E, "push_2e", 0);
    do_cmd(OP_PUSH, 8'h83, "push_83", 0);
    do_cmd(OP_ADD,  8'h00, "add_b1", 0);
    check("done_pulses", 32'(n_done), 32'd3);

    do_cmd(OP_PUSH, 8'hC0, "push_c0", -1);
    do_cmd(OP_PUSH, 8'h50, "push_50", -1);
    do_cmd(OP_ADD,  8'h00, "add_ovf", -1);
    do_cmd(OP_PUSH, 8'h05, "push_05", -1);
    do_cmd(OP_PUSH, 8'h07, "push_07", -1);
    do_cmd(OP_SUB,  8'h00, "sub_borrow", -1);

    do_cmd(OP_CLEAR, 8'h00, "clear_1", -1);
    do_cmd(OP_PUSH, 8'h0C, "push_0c", -1);
    do_cmd(OP_PUSH, 8'h0B, "push_0b", -1);
    do_cmd(OP_MUL,  8'h00, "mul_84", 8);
    do_cmd(OP_PUSH, 8'h10, "push_10", -1);

    // Multiply with a stray strobe while busy: it must be dropped.
    issue(OP_MUL, 8'h00);
    @(negedge clk);
    op_valid = 1'b1; op = OP_PUSH; data_in = 8'h55;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("ign_busy", 32'(busy_s), 32'd1);
    check("ign_nodone", 32'(done_s), 32'd0);
    check("ign_err_hold", 32'(err_s), 32'd0);
    wait_done("mul_ovf", bc);

    do_cmd(OP_CLEAR, 8'h00, "clear_2", -1);
    do_cmd(OP_PUSH, 8'h11, "fill_1", -1);
    do_cmd(OP_PUSH, 8'h22, "fill_2", -1);
    do_cmd(OP_PUSH, 8'h33, "fill_3", -1);
    do_cmd(OP_PUSH, 8'h44, "fill_4", -1);
    do_cmd(OP_PUSH, 8'h99, "push_full", -1);
    do_cmd(OP_DUP,  8'h00, "dup_full", -1);
    do_cmd(OP_CLEAR, 8'h00, "clear_full", -1);
    do_cmd(OP_POP,  8'h00, "pop_under", -1);
    do_cmd(OP_MUL,  8'h00, "mul_under", 0);

    do_cmd(OP_PUSH, 8'h01, "push_1", -1);
    do_cmd(OP_SWAP, 8'h00, "swap_under", -1);
    do_cmd(OP_PUSH, 8'h02, "push_2", -1);
    do_cmd(OP_SWAP, 8'h00, "swap_ok", -1);
    do_cmd(OP_DUP,  8'h00, "dup_ok", -1);

    // Abort a multiply with reset on its 4th busy cycle.
    issue(OP_MUL, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy", 32'(busy_s), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_stk.delete(); m_err = 2'd0; exp_q.delete();
    check("abort_top", 32'(top_s), 32'd0);
    check("abort_next", 32'(next_s), 32'd0);
    check("abort_count", 32'(count_s), 32'd0);
    check("abort_busy0", 32'(busy_s), 32'd0);
    check("abort_done", 32'(done_s), 32'd0);
    check("abort_err", 32'(err_s), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_nodone", 32'(done_s), 32'd0);
    check("abort_idle", 32'(busy_s), 32'd0);
    do_cmd(OP_PUSH, 8'h07, "post_abort_push", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rpn_stack_core.md
# rpn_stack_core

Parametrised, clocked RPN evaluation core: a WIDTH-bit operand stack of DEPTH entries plus an ALU with single-cycle add/sub/stack ops and a multi-cycle shift-add multiplier. It is the next-generation datapath behind the board-level `rpn` top. The top keeps switch/key debouncing, edge detection and seven-segment decoding, and drives this core with one-cycle command pulses. This block adds configurable width and depth, a multiply, and explicit error reporting.

## Interface
- `WIDTH`, 8: operand/result width, ≥2.
- `DEPTH`, 8: stack entries, ≥2.
- `CW`, $clog2(DEPTH+1): count width (derived, not overridden).

- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears stack, aborts any operation.
- `op_valid`  in  1  one-cycle command strobe.
- `op`  in  3  command: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 SWAP, 7 CLEAR.
- `data_in`  in  WIDTH  operand for PUSH, sampled with `op_valid`.
- `top`  out  WIDTH  stack top; 0 when empty.
- `next`  out  WIDTH  entry below top; 0 when count<2.
- `count`  out  CW  occupied entries, 0..DEPTH.
- `busy`  out  1  multiply in progress; commands ignored.
- `done`  out  1  one-cycle pulse after every accepted command completes (including refused ones).
- `err`  out  2  0 none, 1 FULL, 2 UNDERFLOW, 3 OVERFLOW.

## Operation
- FSM states: IDLE, MUL. Reset → IDLE, count=0, all entries 0.
- Command accepted when `op_valid` && !`busy`. When `busy`=1, `op_valid` is dropped silently: no done, err unchanged.
- `err` is replaced on every completion; otherwise holds.
- PUSH: count==DEPTH → refused, err=FULL; else push `data_in`.
- POP: count<1 → UNDERFLOW; else discard top.
- DUP: count<1 → UNDERFLOW; count==DEPTH → FULL; else push copy of top. Underflow is checked first.
- SWAP: count<2 → UNDERFLOW; else exchange top/next.
- ADD/SUB/MUL: count<2 → UNDERFLOW. Else pop both operands and push the result, so count decreases by 1.
  - SUB computes next−top.
  - Unsigned arithmetic. Result is truncated mod 2^WIDTH and still written.
  - err=OVERFLOW on ADD carry-out, SUB borrow (top>next), or nonzero MUL upper WIDTH bits.
- CLEAR: count=0, entries zeroed, err=0; never refused.
- A refused command leaves the stack untouched.

## Timing
- Reset values: top=0, next=0, count=0, busy=0, done=0, err=0, state IDLE.
- Non-MUL ops: accepted at edge N → stack/count/err updated at edge N. `done`=1 for the cycle after N. `busy` stays 0. Back-to-back commands are allowed every cycle.
- MUL: accepted at edge N → state MUL, busy=1 after N. Operands are latched at N and the stack is unchanged during busy. Multiplier runs WIDTH iterations. At edge N+WIDTH: result written, count−1, err set, busy=0, state IDLE, `done`=1 for one cycle. A command may be accepted at edge N+WIDTH+1.
- Refused MUL (underflow) completes like a single-cycle op; busy is never raised.
- `reset` asserted during MUL: aborts at that edge, no done, outputs return to reset values.
- `reset` and `op_valid` in the same cycle: reset wins.

## Structure
- Package `rpn_pkg`: op enum (`OP_PUSH`…`OP_CLEAR`), err enum (`ERR_NONE`, `ERR_FULL`, `ERR_UNDER`, `ERR_OVF`), FSM state enum.
- Sub-module `rpn_mul_seq #(WIDTH)`: start, a, b → after WIDTH cycles done pulse, 2·WIDTH product. Shift-add, one bit per cycle, synchronous active-high reset.
- Stack is a register array with pointer `count`; `top`/`next` are muxed from `count-1`/`count-2`.

## Test plan (WIDTH=8, DEPTH=4)
- Reset → PUSH 0x2E, PUSH 0x83, ADD → top=0xB1, count=1, err=0, done pulses three times.
- PUSH 0xC0, PUSH 0x50, ADD → top=0x10, err=OVERFLOW. Then PUSH 0x05, PUSH 0x07, SUB → top=0xFE, err=OVERFLOW.
- PUSH 0x0C, PUSH 0x0B, MUL → busy high exactly 8 cycles, top=0x84, count=1, err=0. PUSH 0x10, MUL → top=0x40 (0x840 truncated), err=OVERFLOW. An `op_valid` strobe during busy is ignored.
- PUSH ×4 then PUSH 0x99 → err=FULL, count=4, top unchanged. DUP → err=FULL. CLEAR → count=0, top=0, err=0. POP → err=UNDERFLOW.
- PUSH 1, SWAP → err=UNDERFLOW. PUSH 2, SWAP → top=1, next=2.
- Start MUL, assert `reset` on the 4th busy cycle → next cycle all outputs are at reset values, no done. A following PUSH 0x07 gives top=0x07, count=1.
